// File: rtl/mem_stage_ctrl.sv
// ============================================================================
// Module   : mem_stage_ctrl
// Purpose  : Memory-stage sequencer. It takes one load or store at a time from
//            execute, drives the data memory, and returns the response to
//            writeback. Optional build macro MEM_STAT_EN adds completion counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_ctrl #(
    parameter int DEPTH = 256,
    parameter int DW    = 128,
    parameter int AW    = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          req_valid,
    output logic               req_ready,
    input  wire logic          req_is_st,
    input  wire logic [AW-1:0] req_addr,
    input  wire logic [DW-1:0] req_wdata,
    output logic               rsp_valid,
    input  wire logic          rsp_ready,
    output logic               rsp_is_st,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    output logic [1:0]         mem_ctrl,
`ifdef MEM_STAT_EN
    output logic [31:0]        stat_loads,
    output logic [31:0]        stat_stores,
    output logic [31:0]        stat_errs,
`endif
    input  wire logic [DW-1:0] mem_rdata
);

    localparam logic [1:0]    c_MEMNOP = 2'b00;
    localparam logic [1:0]    c_MEMWLD = 2'b01;
    localparam logic [1:0]    c_MEMWST = 2'b10;
    localparam logic [AW-1:0] c_DEPTH  = AW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_req_ready;
    logic          r_rsp_valid;
    logic          r_rsp_is_st;
    logic [DW-1:0] r_rsp_rdata;
    logic          r_rsp_err;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [1:0]    r_mem_ctrl;

    logic w_oor;
    logic w_rsp_hs;

    assign w_oor    = (req_addr >= c_DEPTH);
    assign w_rsp_hs = (r_state == RESP) && rsp_ready;

    // rsp_is_st doubles as the latched request type while the access is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_is_st <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_ctrl  <= c_MEMNOP;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        r_rsp_is_st <= req_is_st;
                        r_rsp_rdata <= '0;
                        if (w_oor) begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= RESP;
                        end else begin
                            r_rsp_err   <= 1'b0;
                            r_mem_addr  <= req_addr;
                            r_mem_wdata <= req_wdata;
                            r_mem_ctrl  <= req_is_st ? c_MEMWST : c_MEMWLD;
                            r_state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (r_rsp_is_st) begin
                        r_mem_ctrl  <= c_MEMNOP;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    r_rsp_rdata <= mem_rdata;
                    r_mem_ctrl  <= c_MEMNOP;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_STAT_EN
    logic [31:0] r_stat_loads;
    logic [31:0] r_stat_stores;
    logic [31:0] r_stat_errs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_loads  <= '0;
            r_stat_stores <= '0;
            r_stat_errs   <= '0;
        end else if (w_rsp_hs) begin
            if (r_rsp_err) begin
                if (r_stat_errs != 32'hFFFF_FFFF)
                    r_stat_errs <= r_stat_errs + 32'd1;
            end else if (r_rsp_is_st) begin
                if (r_stat_stores != 32'hFFFF_FFFF)
                    r_stat_stores <= r_stat_stores + 32'd1;
            end else begin
                if (r_stat_loads != 32'hFFFF_FFFF)
                    r_stat_loads <= r_stat_loads + 32'd1;
            end
        end
    end

    assign stat_loads  = r_stat_loads;
    assign stat_stores = r_stat_stores;
    assign stat_errs   = r_stat_errs;
`else
    logic w_unused;
    assign w_unused = w_rsp_hs;
`endif

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_is_st = r_rsp_is_st;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_ctrl  = r_mem_ctrl;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
// ============================================================================
// Module   : tb_mem_stage_ctrl
// Purpose  : Directed and random load/store traffic for mem_stage_ctrl against
//            a transaction-level memory image and latency model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_stage_ctrl;

    localparam int DEPTH = 256;
    localparam int DW    = 128;
    localparam int AW    = 32;
    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] WLD = 2'b01;
    localparam logic [1:0] WST = 2'b10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_is_st = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_is_st;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [1:0]    mem_ctrl;
    logic [DW-1:0] mem_rdata = '0;
`ifdef MEM_STAT_EN
    logic [31:0]   stat_loads, stat_stores, stat_errs;
    int            exp_ld = 0, exp_st = 0, exp_er = 0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] mem     [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    mem_stage_ctrl #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_is_st  (req_is_st),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_is_st  (rsp_is_st),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ctrl   (mem_ctrl),
`ifdef MEM_STAT_EN
        .stat_loads (stat_loads),
        .stat_stores(stat_stores),
        .stat_errs  (stat_errs),
`endif
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory: registered read, zero output when not reading.
    always @(posedge clk) begin
        if (mem_ctrl == WLD && mem.exists(mem_addr))
            mem_rdata <= mem[mem_addr];
        else
            mem_rdata <= '0;
        if (mem_ctrl == WST)
            mem[mem_addr] = mem_wdata;
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input logic st, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input int hold, input logic keep_valid);
        logic          err;
        int            lat;
        int            cyc;
        logic [DW-1:0] exp_rd;
        err    = (a >= AW'(DEPTH));
        lat    = err ? 1 : (st ? 2 : 3);
        exp_rd = (err || st) ? '0 : (ref_mem.exists(a) ? ref_mem[a] : '0);
        cyc = 0;
        while (!req_ready && cyc < 30) begin
            tick();
            cyc++;
        end
        chk("ready_before_req", DW'(req_ready), DW'(1));
        req_valid = 1'b1;
        req_is_st = st;
        req_addr  = a;
        req_wdata = wd;
        rsp_ready = (hold == 0);
        tick();
        if (!keep_valid) req_valid = 1'b0;
        cyc = 1;
        chk("ready_busy", DW'(req_ready), DW'(0));
        if (!err) begin
            chk("issue_addr", DW'(mem_addr), DW'(a));
            if (st) chk("issue_wdata", mem_wdata, wd);
        end
        while (!rsp_valid && cyc < 10) begin
            chk("ctrl_inflight", DW'(mem_ctrl), DW'(err ? NOP : (st ? WST : WLD)));
            tick();
            cyc++;
        end
        chk("latency", DW'(cyc), DW'(lat));
        for (int k = 0; k <= hold; k++) begin
            chk("rsp_valid", DW'(rsp_valid), DW'(1));
            chk("rsp_is_st", DW'(rsp_is_st), DW'(st));
            chk("rsp_err",   DW'(rsp_err),   DW'(err));
            chk("rsp_rdata", rsp_rdata, exp_rd);
            chk("ready_resp", DW'(req_ready), DW'(0));
            chk("ctrl_resp", DW'(mem_ctrl), DW'(NOP));
            if (k == hold) rsp_ready = 1'b1;
            tick();
        end
        rsp_ready = 1'b0;
        chk("rsp_drop", DW'(rsp_valid), DW'(0));
        chk("idle_ready", DW'(req_ready), DW'(1));
        if (st && !err) ref_mem[a] = wd;
`ifdef MEM_STAT_EN
        if (err) exp_er++;
        else if (st) exp_st++;
        else exp_ld++;
`endif
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          st;

        // Reset state
        tick();
        chk("rst_req_ready", DW'(req_ready), DW'(1));
        chk("rst_rsp_valid", DW'(rsp_valid), DW'(0));
        chk("rst_rsp_is_st", DW'(rsp_is_st), DW'(0));
        chk("rst_rsp_rdata", rsp_rdata, '0);
        chk("rst_rsp_err",   DW'(rsp_err),   DW'(0));
        chk("rst_mem_addr",  DW'(mem_addr),  '0);
        chk("rst_mem_wdata", mem_wdata,      '0);
        chk("rst_mem_ctrl",  DW'(mem_ctrl),  DW'(NOP));
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Asynchronous reset while a load to address 5 sits in WAIT
        req_valid = 1'b1;
        req_is_st = 1'b0;
        req_addr  = 32'd5;
        tick();
        req_valid = 1'b0;
        tick();
        chk("wait_ctrl", DW'(mem_ctrl), DW'(WLD));
        #1 rst = 1'b1;
        #1;
        chk("async_ctrl",  DW'(mem_ctrl),  DW'(NOP));
        chk("async_ready", DW'(req_ready), DW'(1));
        chk("async_valid", DW'(rsp_valid), DW'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("no_rsp_after_rst", DW'(rsp_valid), DW'(0));
        end

        // Store then load at address 7
        do_txn(1'b1, 32'd7, 128'hDEADBEEF_01234567_89ABCDEF_00000001, 0, 1'b0);
        do_txn(1'b0, 32'd7, '0, 0, 1'b0);

        // Top legal address and first illegal address
        do_txn(1'b1, 32'd255, 128'hCAFE_F00D_1234_5678_9ABC_DEF0_1357_2468, 0, 1'b0);
        do_txn(1'b0, 32'd255, '0, 0, 1'b0);
        do_txn(1'b0, 32'd256, '0, 0, 1'b0);
        do_txn(1'b1, 32'h8000_0003, 128'h1, 0, 1'b0);

        // Response back-pressure
        do_txn(1'b1, 32'd3, 128'h0333_0333_0333_0333_0333_0333_0333_0333, 0, 1'b0);
        do_txn(1'b0, 32'd3, '0, 10, 1'b0);

        // req_valid held high through alternating store/load pairs
        for (int i = 0; i < 8; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            do_txn((i % 2) == 0, AW'(i / 2), d, i % 3, 1'b1);
        end
        req_valid = 1'b0;

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            st = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       a = 32'd255;
                1:       a = 32'd256;
                2:       a = $urandom | 32'h0100_0000;
                default: a = AW'($urandom_range(0, 15));
            endcase
            d = {$urandom, $urandom, $urandom, $urandom};
            do_txn(st, a, d, int'($urandom_range(0, 3)), 1'b0);
        end

`ifdef MEM_STAT_EN
        chk("stat_loads",  DW'(stat_loads),  DW'(exp_ld));
        chk("stat_stores", DW'(stat_stores), DW'(exp_st));
        chk("stat_errs",   DW'(stat_errs),   DW'(exp_er));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("stat_loads_rst",  DW'(stat_loads),  '0);
        chk("stat_stores_rst", DW'(stat_stores), '0);
        chk("stat_errs_rst",   DW'(stat_errs),   '0);
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
